// File: rtl/mem_data_port.sv
// mem_data_port: memory-side stage of the MDR path.
// Latches bus bytes into the MDR and performs one RAM read or write at a time,
// waiting a fixed MEM_LATENCY cycles for read data.
// Optional feature macro: ADDR_AUTO_INC_EN. When defined, accesses use an internal
// address register that is loaded by addr_load and advances after every completion.
module mem_data_port #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  mdr_load_bus,
    input  logic                  addr_load,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] bus_data_in,
    output logic [DATA_WIDTH-1:0] MDR_out,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    output logic                  ram_re,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_ISSUE = 3'd1;
    localparam logic [2:0] ST_RD_WAIT  = 3'd2;
    localparam logic [2:0] ST_RD_DONE  = 3'd3;
    localparam logic [2:0] ST_WR_ISSUE = 3'd4;
    localparam logic [2:0] ST_WR_DONE  = 3'd5;

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_LATENCY - 1);

    logic [2:0]            state_q,    state_d;
    logic [DATA_WIDTH-1:0] mdr_q,      mdr_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic [ADDR_WIDTH-1:0] accept_addr;
    logic                  idle;

    assign idle = (state_q == ST_IDLE);

`ifdef ADDR_AUTO_INC_EN
    logic [ADDR_WIDTH-1:0] addr_reg_q, addr_reg_d;

    assign accept_addr = addr_reg_q;

    // Address register: explicit load has priority over post-completion increment.
    always_comb begin
        addr_reg_d = addr_reg_q;
        if (idle && addr_load) begin
            addr_reg_d = addr_in;
        end else if (done) begin
            addr_reg_d = addr_reg_q + 1'b1;
        end
    end

    // Address register storage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_reg_q <= '0;
        end else begin
            addr_reg_q <= addr_reg_d;
        end
    end
`else
    logic unused_addr_load;

    assign accept_addr      = addr_in;
    assign unused_addr_load = addr_load;
`endif

    // Transaction sequencing, MDR updates and address latching.
    always_comb begin
        state_d    = state_q;
        mdr_d      = mdr_q;
        ram_addr_d = ram_addr_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (mdr_load_bus) begin
                    mdr_d = bus_data_in;
                end
                if (mem_write) begin
                    state_d    = ST_WR_ISSUE;
                    ram_addr_d = accept_addr;
                end else if (mem_read) begin
                    state_d    = ST_RD_ISSUE;
                    ram_addr_d = accept_addr;
                end
            end
            ST_RD_ISSUE: begin
                wait_cnt_d = WAIT_LOAD;
                state_d    = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    mdr_d   = ram_rdata;
                    state_d = ST_RD_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_RD_DONE:  state_d = ST_IDLE;
            ST_WR_ISSUE: state_d = ST_WR_DONE;
            ST_WR_DONE:  state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; async reset aborts any access in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            mdr_q      <= '0;
            ram_addr_q <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mdr_q      <= mdr_d;
            ram_addr_q <= ram_addr_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Strobes decode directly from the state register so reset clears them at once.
    assign busy      = !idle;
    assign done      = (state_q == ST_RD_DONE) || (state_q == ST_WR_DONE);
    assign ram_re    = (state_q == ST_RD_ISSUE);
    assign ram_we    = (state_q == ST_WR_ISSUE);
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = mdr_q;
    assign MDR_out   = mdr_q;

endmodule

// File: tb/tb_mem_data_port.sv
// Scoreboard bench for mem_data_port: the stimulus process queues expected
// transactions, a negedge monitor checks RAM strobes and completions against them.
module tb_mem_data_port;

    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int LAT = 2;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          mem_read, mem_write, mdr_load_bus, addr_load;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] bus_data_in;
    logic [DW-1:0] MDR_out;
    logic          busy, done;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we, ram_re;
    logic [DW-1:0] ram_rdata;

    mem_data_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mdr_load_bus(mdr_load_bus),
        .addr_load   (addr_load),
        .addr_in     (addr_in),
        .bus_data_in (bus_data_in),
        .MDR_out     (MDR_out),
        .busy        (busy),
        .done        (done),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_we      (ram_we),
        .ram_re      (ram_re),
        .ram_rdata   (ram_rdata)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // RAM model: read data becomes valid LAT cycles after the ram_re cycle.
    logic [DW-1:0] mem [0:65535];
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    int            pend = 0;
    logic [AW-1:0] pend_addr = '0;

    always @(posedge clock) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (pend == 1) ram_rdata <= mem[pend_addr];
        if (pend > 0) pend <= pend - 1;
        if (ram_re) begin
            if (LAT == 1) begin
                ram_rdata <= mem[ram_addr];
            end else begin
                pend      <= LAT - 1;
                pend_addr <= ram_addr;
                ram_rdata <= 8'hEE;
            end
        end
    end

    typedef struct {
        bit          is_wr;
        logic [15:0] addr;
        logic [7:0]  data;
        int unsigned t0;
    } exp_t;

    exp_t exp_q[$];
    bit   issued = 1'b0;
    int   checks = 0;
    int   failures = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    // Monitor: compares every RAM strobe and every done against the queue head.
    always @(negedge clock) begin
        if (!reset_n) begin
            issued = 1'b0;
        end else begin
            if (ram_re && ram_we) chk("re_we_exclusive", {ram_re, ram_we}, 2'b00);
            if (ram_re || ram_we) begin
                chk("ram_op_pending", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    chk("op_kind", ram_we, exp_q[0].is_wr);
                    chk("op_single", issued, 0);
                    chk("op_addr", ram_addr, exp_q[0].addr);
                    if (ram_we) chk("op_wdata", ram_wdata, exp_q[0].data);
                    issued = 1'b1;
                end
            end
            if (done) begin
                chk("done_pending", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_after_op", issued, 1);
                    issued = 1'b0;
                    chk("done_mdr", MDR_out, e.data);
                    chk("done_latency", cyc - e.t0, e.is_wr ? 32'd2 : 32'(2 + LAT));
                    chk("done_addr", ram_addr, e.addr);
                    chk("done_busy", busy, 1);
                end
            end
        end
    end

    task automatic push_exp(input bit wr, input logic [15:0] a, input logic [7:0] d, input int unsigned t0);
        exp_t e;
        e.is_wr = wr;
        e.addr  = a;
        e.data  = d;
        e.t0    = t0;
        exp_q.push_back(e);
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        @(posedge clock); #1;
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clock); #1;
        pre_en = 1'b0;
    endtask

    // Drive one strobe cycle; in auto-increment builds the address is loaded first.
    task automatic issue(input bit rd, input bit wr, input bit ld, input logic [15:0] a,
                         input logic [7:0] bd, input logic [7:0] exp_data);
        @(posedge clock); #1;
`ifdef ADDR_AUTO_INC_EN
        addr_load = 1'b1; addr_in = a;
        @(posedge clock); #1;
        addr_load = 1'b0;
`endif
        addr_in = a; mem_read = rd; mem_write = wr; mdr_load_bus = ld; bus_data_in = bd;
        if (rd || wr) push_exp(wr, a, exp_data, cyc);
        @(posedge clock); #1;
        mem_read = 1'b0; mem_write = 1'b0; mdr_load_bus = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clock); #1;
            if (!busy && exp_q.size() == 0) ok = 1'b1;
        end
        chk(nm, ok, 1);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_re"}, ram_re, 0);
        chk({nm, "_we"}, ram_we, 0);
        chk({nm, "_mdr"}, MDR_out, 0);
        chk({nm, "_addr"}, ram_addr, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; mdr_load_bus = 1'b0; addr_load = 1'b0;
        addr_in = '0; bus_data_in = '0;
        preload(16'h0040, 8'hA5);
        preload(16'h0300, 8'hC7);
        preload(16'hFFFF, 8'h11);
        preload(16'h0000, 8'h22);
        chk_reset_outputs("reset");
        @(posedge clock); #1;
        reset_n = 1'b1;

        // Basic read.
        issue(1, 0, 0, 16'h0040, 8'h00, 8'hA5);
        wait_idle("rd_idle");
        chk("rd_mdr_hold", MDR_out, 8'hA5);
        addr_in = 16'h5555;
        @(posedge clock); #1;
        chk("addr_hold_idle", ram_addr, 16'h0040);

        // Load MDR from bus and write it in the same cycle.
        issue(0, 1, 1, 16'h0100, 8'h3C, 8'h3C);
        wait_idle("wr_idle");
        chk("wr_mdr", MDR_out, 8'h3C);

        // Both strobes: write wins.
        issue(1, 1, 1, 16'h0200, 8'h5A, 8'h5A);
        wait_idle("rw_idle");
        issue(1, 0, 0, 16'h0200, 8'h00, 8'h5A);
        wait_idle("rw_readback");
        issue(1, 0, 0, 16'h0100, 8'h00, 8'h3C);
        wait_idle("wr_readback");

        // Strobes and MDR loads while busy are ignored.
        issue(1, 0, 0, 16'h0300, 8'h00, 8'hC7);
        mem_read = 1'b1; mem_write = 1'b1; mdr_load_bus = 1'b1; bus_data_in = 8'h77;
        @(posedge clock); #1;
        @(posedge clock); #1;
        mem_read = 1'b0; mem_write = 1'b0; mdr_load_bus = 1'b0;
        wait_idle("busy_idle");
        chk("busy_mdr", MDR_out, 8'hC7);

`ifndef ADDR_AUTO_INC_EN
        // Strobe held across done: re-accepted in the following IDLE cycle.
        @(posedge clock); #1;
        addr_in = 16'h0040; mem_read = 1'b1;
        push_exp(0, 16'h0040, 8'hA5, cyc);
        push_exp(0, 16'h0300, 8'hC7, cyc + 5);
        @(posedge clock); #1;
        addr_in = 16'h0300;
        repeat (5) @(posedge clock);
        #1;
        mem_read = 1'b0;
        wait_idle("b2b_idle");
`endif

        // Reset while ram_re is high.
        issue(1, 0, 0, 16'h0040, 8'h00, 8'hA5);
        chk("rst_issue_re", ram_re, 1);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk_reset_outputs("rst_issue");
        @(posedge clock); #1;
        reset_n = 1'b1;

        // Reset during RD_WAIT.
        issue(1, 0, 0, 16'h0040, 8'h00, 8'hA5);
        @(posedge clock); #2;
        chk("rst_wait_busy_pre", busy, 1);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk_reset_outputs("rst_wait");
        @(posedge clock); #1;
        reset_n = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        chk("rst_no_done_busy", busy, 0);
        chk("rst_no_done_mdr", MDR_out, 8'h00);

`ifdef ADDR_AUTO_INC_EN
        // Auto-increment wraps from all-ones to zero.
        @(posedge clock); #1;
        addr_load = 1'b1; addr_in = 16'hFFFF;
        @(posedge clock); #1;
        addr_load = 1'b0; addr_in = 16'h1234; mem_read = 1'b1;
        push_exp(0, 16'hFFFF, 8'h11, cyc);
        @(posedge clock); #1;
        mem_read = 1'b0;
        wait_idle("inc_first");
        @(posedge clock); #1;
        mem_read = 1'b1;
        push_exp(0, 16'h0000, 8'h22, cyc);
        @(posedge clock); #1;
        mem_read = 1'b0;
        wait_idle("inc_wrap");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
